// File: rtl/mac_sequencer.sv
// Sequencer for an 8x8 matrix-vector multiply: pops the A-row and B FIFOs and steers 8 MAC units.
// Optional systolic skew of the A rows is enabled by defining MAC_SEQ_SKEW_EN.
module mac_sequencer (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a_full,
    input  logic [7:0] a_empty,
    input  logic       b_full,
    input  logic       b_empty,
    output logic [7:0] a_rden,
    output logic       b_rden,
    output logic       mac_clr,
    output logic [7:0] mac_en,
    output logic       busy,
    output logic       done,
    output logic       err
);

`ifdef MAC_SEQ_SKEW_EN
    localparam logic [3:0] LAST_CNT = 4'd14;
`else
    localparam logic [3:0] LAST_CNT = 4'd7;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       mac_clr_q;
    logic [7:0] mac_en_q;
    logic       busy_q;
    logic       done_q;
    logic       err_q;

    logic [7:0] sched_a;
    logic       sched_b;
    logic       underflow;
    logic       all_full;

    // Read schedule for the current RUN cycle; row k reads during its window of 8 cycles.
    always_comb begin
        sched_a = 8'h00;
        sched_b = 1'b0;
        if (state_q == ST_RUN) begin
            sched_b = (cnt_q <= 4'd7);
`ifdef MAC_SEQ_SKEW_EN
            for (int k = 0; k < 8; k++) begin
                sched_a[k] = (cnt_q >= 4'(k)) && (cnt_q <= 4'(k + 7));
            end
`else
            sched_a = sched_b ? 8'hFF : 8'h00;
`endif
        end
    end

    // A scheduled read to an empty FIFO is dropped and aborts the pass.
    assign underflow = (|(sched_a & a_empty)) | (sched_b & b_empty);
    assign a_rden    = sched_a & ~a_empty;
    assign b_rden    = sched_b & ~b_empty;
    assign all_full  = (a_full == 8'hFF) && b_full;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            mac_clr_q <= 1'b0;
            mac_en_q  <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            mac_clr_q <= 1'b0;
            done_q    <= 1'b0;
            mac_en_q  <= a_rden;
            case (state_q)
                ST_IDLE: begin
                    if (start && all_full) begin
                        state_q   <= ST_CLEAR;
                        mac_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                        err_q     <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    state_q <= ST_RUN;
                    cnt_q   <= 4'd0;
                end
                ST_RUN: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (underflow) begin
                        err_q <= 1'b1;
                    end
                    if (underflow || (cnt_q == LAST_CNT)) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 4'd0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mac_clr = mac_clr_q;
    assign mac_en  = mac_en_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
